pow_decoder_seq: RTL and testbench

- Sequential inverse of the team's `pow` priority encoder: takes an exponent and returns the one-hot word 2^exp.
- Sits on the return path, where encoded power indices are expanded back into bit masks for downstream logic.
- Uses an iterative single-bit left shifter (one shift per clock), with valid/ready handshakes on input and output.
- Flags exponents that do not fit in the output width.

---
 rtl/pow_decoder_seq.sv | 105 ++++++++++
 tb/tb_pow_decoder_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pow_decoder_seq.sv
// pow_decoder_seq: sequential exponent-to-one-hot decoder (2^in_pow).
// A WIDTH-bit register is seeded with 1 and shifted left once per clock,
// counted down from in_pow. Exponents that do not fit in WIDTH bits are
// flagged through out_err with an all-zero result.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a request, in_ready high
//   SHIFT | shifting the one-hot bit towards position in_pow
//   DONE  | result presented with out_valid, held until out_ready
module pow_decoder_seq #(
    parameter int WIDTH = 8,
    parameter int EXP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] in_pow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_num,
    output logic             out_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // One extra bit so WIDTH == 2**EXP_W is representable and the compare is exact.
    localparam logic [EXP_W:0] WIDTH_C = (EXP_W + 1)'(WIDTH);

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] num_q;
    logic [EXP_W-1:0] cnt;
    logic             err;
    logic             err_q;
    logic             out_of_range;
    logic [WIDTH-1:0] shreg_next;

    assign out_of_range = ({1'b0, in_pow} >= WIDTH_C);
    assign shreg_next   = {shreg[WIDTH-2:0], 1'b0};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_num   = num_q;
    assign out_err   = err_q;

    // Handshake FSM, shifter, down-counter and the held output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            err   <= 1'b0;
            num_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (out_of_range) begin
                            shreg <= '0;
                            err   <= 1'b1;
                            num_q <= '0;
                            err_q <= 1'b1;
                            state <= DONE;
                        end else if (in_pow == '0) begin
                            shreg <= WIDTH'(1);
                            err   <= 1'b0;
                            num_q <= WIDTH'(1);
                            err_q <= 1'b0;
                            state <= DONE;
                        end else begin
                            shreg <= WIDTH'(1);
                            cnt   <= in_pow;
                            err   <= 1'b0;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    shreg <= shreg_next;
                    cnt   <= cnt - EXP_W'(1);
                    // Outputs only change when a new result is published.
                    if (cnt == EXP_W'(1)) begin
                        num_q <= shreg_next;
                        err_q <= err;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pow_decoder_seq.sv
// Scoreboard bench for pow_decoder_seq: accepted requests push the expected
// word, error flag and first-valid cycle; a monitor pops on each new result.
module tb_pow_decoder_seq;

    localparam int WIDTH = 8;
    localparam int EXP_W = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [EXP_W-1:0] in_pow;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_num;
    logic             out_err;

    typedef struct {
        logic [WIDTH-1:0] num;
        logic             err;
        int               cyc;
    } exp_t;

    exp_t             q[$];
    int               checks   = 0;
    int               failures = 0;
    int               cyc      = 0;
    int               rmode    = 0;
    bit               checked  = 0;
    logic [WIDTH-1:0] hold_num;
    logic             hold_err;

    pow_decoder_seq #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pow    (in_pow),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_num   (out_num),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: 2**p when it fits in WIDTH bits, else zero with error;
    // first valid cycle is p edges after accept (0 for p==0 and errors).
    function automatic exp_t model(input int p, input int accept_edge);
        exp_t e;
        if (p >= WIDTH) begin
            e.num = '0;
            e.err = 1'b1;
            e.cyc = accept_edge;
        end else begin
            e.num = WIDTH'(2 ** p);
            e.err = 1'b0;
            e.cyc = accept_edge + p;
        end
        return e;
    endfunction

    // Acceptance observer: inputs are stable at negedge, so accept happens on the next edge.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) q.push_back(model(int'(in_pow), cyc + 1));
    end

    // Output monitor.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            chk("in_ready_low_in_done", 32'(in_ready), 32'd0);
            chk("onehot_or_zero", 32'($countones(out_num) <= 1), 32'd1);
            if (!checked) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_num", 32'(out_num), 32'(e.num));
                    chk("out_err", 32'(out_err), 32'(e.err));
                    chk("latency_cycle", 32'(cyc), 32'(e.cyc));
                end
                hold_num = out_num;
                hold_err = out_err;
                checked  = 1;
            end else begin
                chk("hold_num", 32'(out_num), 32'(hold_num));
                chk("hold_err", 32'(out_err), 32'(hold_err));
            end
            if (out_ready) checked = 0;
        end
    end

    // Consumer: 0 = always ready, 1 = stalled, 2 = random.
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Issue one request; called at posedge+1, returns at posedge+1 after the accept edge.
    task automatic req(input logic [EXP_W-1:0] p);
        int n = 0;
        in_valid = 1'b1;
        in_pow   = p;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd1, 32'd0);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "request never accepted");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_pow   = EXP_W'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pow    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_num", 32'(out_num), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        @(posedge clk);
        #1;

        // Directed: zero, mid, MSB, out-of-range, recovery after error.
        rmode = 0;
        req(4'd0);
        @(negedge clk);
        @(negedge clk);
        chk("in_ready_after_pow0", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        req(4'd5);
        req(4'd7);
        req(4'd9);
        req(4'd2);
        drain();

        // Backpressure: result held while in_valid toggles with a pending request.
        rmode = 1;
        req(4'd3);
        for (int i = 0; i < 14; i++) begin
            in_valid = ~in_valid;
            in_pow   = 4'd6;
            @(negedge clk);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            if (i >= 4) chk("bp_out_num", 32'(out_num), 32'h08);
            @(posedge clk);
            #1;
        end
        rmode = 0;
        req(4'd6);
        drain();

        // Asynchronous reset in the middle of a shift sequence.
        rmode = 0;
        req(4'd6);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_num", 32'(out_num), 32'd0);
        chk("arst_out_err", 32'(out_err), 32'd0);
        q.delete();
        checked = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        req(4'd1);
        drain();

        // Random requests with random consumer stalls and idle gaps.
        rmode = 2;
        for (int i = 0; i < 80; i++) begin
            req(EXP_W'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        rmode = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        chk("global_timeout", 32'd1, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation timeout");
    end

endmodule
